// File: rtl/wb_gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// wb_gpio_irq_ctrl
//   Wishbone B4 classic slave that owns the user GPIO pads. Software-written
//   registers drive io_out / io_oeb. io_in passes through a 2-flop
//   synchronizer. Rising edges on enabled pins set sticky status bits. A
//   registered level interrupt is raised while any status bit is pending.
//
// Ports
//   wb_clk_i, wb_rst_n_i      clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i      Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]            byte-lane enables
//   wbs_adr_i[31:0]           byte address (window = BASE_ADDR[31:8])
//   wbs_dat_i[31:0]           write data
//   wbs_dat_o[31:0]           read data (valid in the ack cycle, else 0)
//   wbs_ack_o                 transfer acknowledge
//   io_in[NUM_IO-1:0]         asynchronous pad inputs
//   io_out[NUM_IO-1:0]        pad output values
//   io_oeb[NUM_IO-1:0]        pad output enables, active-low
//   irq_o                     level interrupt (= |STAT, registered)
//
// Register map (offset = wbs_adr_i[7:0]); LO = bits [31:0], HI = [NUM_IO-1:32]
//   0x00/0x04 OUT RW   0x08/0x0C OEB RW   0x10/0x14 IN RO
//   0x18/0x1C IEN RW   0x20/0x24 STAT W1C
// -----------------------------------------------------------------------------
module wb_gpio_irq_ctrl #(
  parameter int unsigned NUM_IO    = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq_o
);

  // Bits at or above NUM_IO do not exist: they are forced to 0 everywhere.
  localparam logic [63:0] IO_MASK = (NUM_IO >= 64) ? {64{1'b1}}
                                                   : ((64'd1 << NUM_IO) - 64'd1);

  localparam logic [7:0] OFF_OUT_LO  = 8'h00;
  localparam logic [7:0] OFF_OUT_HI  = 8'h04;
  localparam logic [7:0] OFF_OEB_LO  = 8'h08;
  localparam logic [7:0] OFF_OEB_HI  = 8'h0C;
  localparam logic [7:0] OFF_IN_LO   = 8'h10;
  localparam logic [7:0] OFF_IN_HI   = 8'h14;
  localparam logic [7:0] OFF_IEN_LO  = 8'h18;
  localparam logic [7:0] OFF_IEN_HI  = 8'h1C;
  localparam logic [7:0] OFF_STAT_LO = 8'h20;
  localparam logic [7:0] OFF_STAT_HI = 8'h24;

  logic [63:0] out_q,   out_d;
  logic [63:0] oeb_q,   oeb_d;
  logic [63:0] ien_q,   ien_d;
  logic [63:0] stat_q,  stat_d;
  logic [63:0] sync1_q, sync2_q, prev_q;
  logic        ack_q,   ack_d;
  logic [31:0] dat_q,   dat_d;
  logic        irq_q;

  logic [63:0] io_in_ext;
  logic [63:0] edge_det;
  logic [63:0] w1c_clr;
  logic [31:0] bmask;
  logic [31:0] rdata;
  logic [7:0]  off;
  logic        hit, req, wr, rd;

  // Handshake: a request is cyc & stb & window hit while ack is low. ack is
  // registered, rises the cycle after the request and lasts exactly one
  // cycle; the forced low cycle makes each transfer take 2 cycles. Writes
  // commit on the request edge; read data is presented only during ack.
  assign off  = wbs_adr_i[7:0];
  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req  = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr   = req & wbs_we_i;
  assign rd   = req & ~wbs_we_i;
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign io_in_ext = 64'(io_in) & IO_MASK;
  assign edge_det  = sync2_q & ~prev_q & ien_q;

  always_comb begin
    out_d   = out_q;
    oeb_d   = oeb_q;
    ien_d   = ien_q;
    w1c_clr = 64'd0;
    if (wr) begin
      unique case (off)
        OFF_OUT_LO:  out_d[31:0]  = (out_q[31:0]  & ~bmask) | (wbs_dat_i & bmask);
        OFF_OUT_HI:  out_d[63:32] = (out_q[63:32] & ~bmask) | (wbs_dat_i & bmask);
        OFF_OEB_LO:  oeb_d[31:0]  = (oeb_q[31:0]  & ~bmask) | (wbs_dat_i & bmask);
        OFF_OEB_HI:  oeb_d[63:32] = (oeb_q[63:32] & ~bmask) | (wbs_dat_i & bmask);
        OFF_IEN_LO:  ien_d[31:0]  = (ien_q[31:0]  & ~bmask) | (wbs_dat_i & bmask);
        OFF_IEN_HI:  ien_d[63:32] = (ien_q[63:32] & ~bmask) | (wbs_dat_i & bmask);
        OFF_STAT_LO: w1c_clr[31:0]  = wbs_dat_i & bmask;
        OFF_STAT_HI: w1c_clr[63:32] = wbs_dat_i & bmask;
        default: ;  // IN registers and unmapped offsets ignore writes
      endcase
    end
    out_d = out_d & IO_MASK;
    oeb_d = oeb_d & IO_MASK;
    ien_d = ien_d & IO_MASK;
    // Set after clear: a new edge on the same cycle as a W1C wins.
    stat_d = ((stat_q & ~w1c_clr) | edge_det) & IO_MASK;
  end

  always_comb begin
    rdata = 32'd0;
    unique case (off)
      OFF_OUT_LO:  rdata = out_q[31:0];
      OFF_OUT_HI:  rdata = out_q[63:32];
      OFF_OEB_LO:  rdata = oeb_q[31:0];
      OFF_OEB_HI:  rdata = oeb_q[63:32];
      OFF_IN_LO:   rdata = sync2_q[31:0];
      OFF_IN_HI:   rdata = sync2_q[63:32];
      OFF_IEN_LO:  rdata = ien_q[31:0];
      OFF_IEN_HI:  rdata = ien_q[63:32];
      OFF_STAT_LO: rdata = stat_q[31:0];
      OFF_STAT_HI: rdata = stat_q[63:32];
      default:     rdata = 32'd0;
    endcase
  end

  assign ack_d = req;
  assign dat_d = rd ? rdata : 32'd0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      out_q   <= 64'd0;
      oeb_q   <= IO_MASK;
      ien_q   <= 64'd0;
      stat_q  <= 64'd0;
      sync1_q <= 64'd0;
      sync2_q <= 64'd0;
      prev_q  <= 64'd0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      ien_q   <= ien_d;
      stat_q  <= stat_d;
      sync1_q <= io_in_ext;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= |stat_q;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q[NUM_IO-1:0];
  assign io_oeb    = oeb_q[NUM_IO-1:0];
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio_irq_ctrl
//   Table-driven register checks followed by hand-written sequences for the
//   edge/interrupt path, same-cycle set vs W1C, address miss and mid-transfer
//   reset.
// -----------------------------------------------------------------------------
module tb_wb_gpio_irq_ctrl;

  localparam int NIO = 38;

  logic            clk;
  logic            rst_n;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, dat_w;
  logic [31:0]     dat_r;
  logic            ack;
  logic [NIO-1:0]  io_in;
  logic [NIO-1:0]  io_out;
  logic [NIO-1:0]  io_oeb;
  logic            irq;

  int n_cmp = 0;
  int n_err = 0;

  wb_gpio_irq_ctrl #(.NUM_IO(NIO), .BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_w),
    .wbs_dat_o  (dat_r),
    .wbs_ack_o  (ack),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq_o      (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives a request at the falling edge, waits (bounded) for ack, keeps
  // stb high for one more edge to confirm ack drops by itself, then releases.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdat,
                         output int lat, output logic ack_after);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat  = 0;
    rdat = 32'hDEAD_BEEF;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat  = i;
        rdat = dat_r;
        break;
      end
    end
    @(posedge clk); #1;
    ack_after = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; int l; logic aa;
    wb_xfer(1'b1, a, d, s, r, l, aa);
    chk("wr_ack_latency", 64'(l), 64'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    int l; logic aa;
    wb_xfer(1'b0, a, 32'd0, 4'hF, r, l, aa);
    chk("rd_ack_latency", 64'(l), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        do_wr;
    logic [7:0]  wr_off;
    logic [31:0] wr_dat;
    logic [3:0]  wr_sel;
    logic [7:0]  rd_off;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] r;
    int          lat;
    logic        aa;
    int          acks;

    //            wr   woff   wdata          sel      roff   expected
    vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0,  8'h08, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0,  8'h0C, 32'h0000_003F};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,         4'h0,  8'h00, 32'h0000_0000};
    vecs[3]  = '{1'b0, 8'h00, 32'h0,         4'h0,  8'h20, 32'h0000_0000};
    vecs[4]  = '{1'b1, 8'h00, 32'hA5A5_A5A5, 4'b0010, 8'h00, 32'h0000_A500};
    vecs[5]  = '{1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF,  8'h04, 32'h0000_003F};
    vecs[6]  = '{1'b1, 8'h0C, 32'h0000_0000, 4'b0001, 8'h0C, 32'h0000_0000};
    vecs[7]  = '{1'b1, 8'h08, 32'h1234_5678, 4'b1100, 8'h08, 32'h1234_FFFF};
    vecs[8]  = '{1'b1, 8'h1C, 32'hFFFF_FFFF, 4'hF,  8'h1C, 32'h0000_003F};
    vecs[9]  = '{1'b1, 8'h1C, 32'h0000_0000, 4'hF,  8'h1C, 32'h0000_0000};
    vecs[10] = '{1'b1, 8'h18, 32'hC3C3_C3C3, 4'b0101, 8'h18, 32'h00C3_00C3};
    vecs[11] = '{1'b1, 8'h18, 32'h0000_0000, 4'hF,  8'h18, 32'h0000_0000};
    vecs[12] = '{1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF,  8'h10, 32'h0000_0000};
    vecs[13] = '{1'b1, 8'h00, 32'h5A5A_5A5A, 4'h0,  8'h00, 32'h0000_A500};
    vecs[14] = '{1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF,  8'h40, 32'h0000_0000};
    vecs[15] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 4'b0001, 8'h00, 32'h0000_A5FF};

    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0; io_in = '0;
    rst_n = 1'b0;
    idle(3);
    chk("reset_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("reset_io_out", 64'(io_out), 64'd0);
    chk("reset_irq",    64'(irq),    64'd0);
    chk("reset_ack",    64'(ack),    64'd0);
    chk("reset_dat",    64'(dat_r),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // ack exactly one cycle, one cycle after stb
    wb_xfer(1'b0, 32'h3000_0008, 32'd0, 4'hF, r, lat, aa);
    chk("ack_latency", 64'(lat), 64'd1);
    chk("ack_one_cycle", 64'(aa), 64'd0);
    chk("dat_zero_after_ack", 64'(dat_r), 64'd0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_wr)
        wb_write(32'h3000_0000 | 32'(vecs[i].wr_off), vecs[i].wr_dat, vecs[i].wr_sel);
      wb_read(32'h3000_0000 | 32'(vecs[i].rd_off), r);
      chk($sformatf("vec%0d_off%02h", i, vecs[i].rd_off), 64'(r), 64'(vecs[i].exp));
    end
    chk("pins_io_out", 64'(io_out), 64'h3F_0000_A5FF);
    chk("pins_io_oeb", 64'(io_oeb), 64'h00_1234_FFFF);

    // Synchronized input readback; IEN=0 so rising edges must not set STAT.
    @(negedge clk);
    io_in = 38'h15_8765_4320;
    idle(4);
    wb_read(32'h3000_0010, r); chk("in_lo", 64'(r), 64'h8765_4320);
    wb_read(32'h3000_0014, r); chk("in_hi", 64'(r), 64'h0000_0015);
    wb_read(32'h3000_0020, r); chk("stat_no_ien", 64'(r), 64'd0);
    chk("irq_no_ien", 64'(irq), 64'd0);
    @(negedge clk);
    io_in = '0;
    idle(4);

    // Edge on io_in[0]: STAT at the 3rd edge, irq at the 4th.
    wb_write(32'h3000_0018, 32'h1, 4'hF);
    @(negedge clk);
    io_in[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (irq) begin lat = i; break; end
    end
    chk("irq_latency", 64'(lat), 64'd4);
    wb_read(32'h3000_0020, r); chk("stat_set", 64'(r), 64'h1);
    wb_write(32'h3000_0020, 32'h1, 4'hF);
    chk("irq_cleared", 64'(irq), 64'd0);
    wb_read(32'h3000_0020, r); chk("stat_cleared", 64'(r), 64'd0);

    // Re-arm STAT, then raise a new edge on the same cycle as the W1C.
    @(negedge clk); io_in[0] = 1'b0; idle(4);
    @(negedge clk); io_in[0] = 1'b1; idle(5);
    chk("irq_rearmed", 64'(irq), 64'd1);
    @(negedge clk); io_in[0] = 1'b0; idle(4);
    chk("irq_held", 64'(irq), 64'd1);
    @(negedge clk); io_in[0] = 1'b1;
    @(posedge clk);             // sync1 <= 1
    @(posedge clk);             // sync2 <= 1: edge active until next edge
    wb_write(32'h3000_0020, 32'h1, 4'hF);  // request sampled with edge active
    chk("irq_set_wins", 64'(irq), 64'd1);
    wb_read(32'h3000_0020, r); chk("stat_set_wins", 64'(r), 64'h1);

    // Disabling IEN leaves pending STAT alone.
    wb_write(32'h3000_0018, 32'h0, 4'hF);
    wb_read(32'h3000_0020, r); chk("stat_after_ien_off", 64'(r), 64'h1);
    chk("irq_after_ien_off", 64'(irq), 64'd1);

    // Address miss: next 256-byte page must never ack or change state.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0100;
    dat_w = 32'hFFFF_FFFF; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("miss_no_ack", 64'(acks), 64'd0);
    wb_read(32'h3000_0000, r); chk("miss_out_lo", 64'(r), 64'h0000_A5FF);

    // Reset while ack is high: ack drops without a clock edge.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0008; sel = 4'hF;
    @(posedge clk); #1;
    chk("pre_reset_ack", 64'(ack), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ack_async", 64'(ack), 64'd0);
    chk("reset_irq_async", 64'(irq), 64'd0);
    chk("reset_oeb_async", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("reset_out_async", 64'(io_out), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    wb_read(32'h3000_0008, r); chk("post_rst_oeb_lo", 64'(r), 64'hFFFF_FFFF);
    wb_read(32'h3000_0004, r); chk("post_rst_out_hi", 64'(r), 64'd0);
    wb_read(32'h3000_0020, r); chk("post_rst_stat", 64'(r), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
